mxu_axi_wr_slave: RTL and testbench

//  AXI4-Lite write-channel slave in front of the MXU byte cache: accepts AW and W independently, joins them into one

---
 rtl/mxu_axi_wr_slave.sv | 196 +++++++++++++++++++
 tb/tb_mxu_axi_wr_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_axi_wr_slave.sv
// ---------------------------------------------------------------------------
// mxu_axi_wr_slave
//
// AXI4-Lite write-channel slave in front of the MXU byte cache. The AW and W
// channels each land in a one-entry slot, in either order. When both slots are
// full and no B response is still owed, the slave performs the join ("fire").
// A fire produces one word-aligned, byte-strobed cache write and one B
// response. A write of bit 0 of byte 0 also raises a one-cycle start request
// to the control FSM.
//
// Optional feature (macro MXU_WR_BUSY_LOCK_EN):
//   When defined and busy=1, the following writes get SLVERR and do not
//   write the cache:
//     - writes whose aligned address is in the data region (>= 6);
//     - start requests, which also raise no start_pulse.
//   Writes to control bytes 0..5 are still accepted.
//   When undefined, busy is ignored.
//
// Ports
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   awaddr/awvalid/awready   AXI write address channel
//   wdata/wstrb/wvalid/wready AXI write data channel
//   bresp/bvalid/bready      AXI write response channel (00 OKAY, 10 SLVERR)
//   cache_we/cache_addr/cache_wdata/cache_wstrb  one-cycle cache write port
//   start_pulse         one-cycle start request to the control FSM
//   busy                control FSM running
// ---------------------------------------------------------------------------
module mxu_axi_wr_slave #(
    parameter  int SIZE        = 16,
    localparam int CACHE_BYTES = 2 * SIZE * SIZE + 7,
    localparam int ADDR_W      = $clog2(CACHE_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              cache_we,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [31:0]       cache_wdata,
    output logic [3:0]        cache_wstrb,
    output logic              start_pulse,
    input  logic              busy
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The last byte of the addressed word must lie inside the cache.
    function automatic logic word_in_range(input logic [15:2] word);
        return ({16'd0, word, 2'b11} < 32'(CACHE_BYTES));
    endfunction

    // Slot state
    logic              aw_full_q, aw_full_d;
    logic              w_full_q,  w_full_d;
    logic [15:2]       awaddr_q,  awaddr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;

    // Registered outputs
    logic              bvalid_q,      bvalid_d;
    logic [1:0]        bresp_q,       bresp_d;
    logic              cache_we_q,    cache_we_d;
    logic [ADDR_W-1:0] cache_addr_q,  cache_addr_d;
    logic [31:0]       cache_wdata_q, cache_wdata_d;
    logic [3:0]        cache_wstrb_q, cache_wstrb_d;
    logic              start_q,       start_d;

    logic aw_hs_s, w_hs_s, fire_s, in_range_s, start_req_s, lock_s, okay_s;
    logic unused_s;

    // Ready comes only from slot state. It is also held low while reset is
    // high, so no handshake is offered during reset.
    assign awready = ~aw_full_q & ~reset;
    assign wready  = ~w_full_q  & ~reset;

    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign cache_we    = cache_we_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wdata = cache_wdata_q;
    assign cache_wstrb = cache_wstrb_q;
    assign start_pulse = start_q;

`ifdef MXU_WR_BUSY_LOCK_EN
    assign unused_s = ^awaddr[1:0];
`else
    assign unused_s = ^{awaddr[1:0], busy};
`endif

    // Handshakes, the join decision and the response classification.
    always_comb begin
        aw_hs_s     = awvalid & awready;
        w_hs_s      = wvalid & wready;
        // A fire may coincide with the cycle that retires the previous B.
        fire_s      = aw_full_q & w_full_q & (~bvalid_q | bready);
        in_range_s  = word_in_range(awaddr_q);
        start_req_s = (awaddr_q == 14'd0) & wstrb_q[0] & wdata_q[0];
`ifdef MXU_WR_BUSY_LOCK_EN
        lock_s      = busy & (({awaddr_q, 2'b00} >= 16'd6) | start_req_s);
`else
        lock_s      = 1'b0;
`endif
        okay_s      = in_range_s & ~lock_s;
    end

    // Next-state for slots, B channel and the cache write port.
    always_comb begin
        aw_full_d     = aw_full_q;
        w_full_d      = w_full_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        cache_we_d    = 1'b0;
        start_d       = 1'b0;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        cache_wstrb_d = cache_wstrb_q;

        // A full slot never handshakes, so fire and capture are exclusive.
        if (fire_s) begin
            aw_full_d = 1'b0;
        end else if (aw_hs_s) begin
            aw_full_d = 1'b1;
            awaddr_d  = awaddr[15:2];
        end else begin
            aw_full_d = aw_full_q;
        end

        if (fire_s) begin
            w_full_d = 1'b0;
        end else if (w_hs_s) begin
            w_full_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end else begin
            w_full_d = w_full_q;
        end

        if (fire_s) begin
            bvalid_d      = 1'b1;
            bresp_d       = okay_s ? RESP_OKAY : RESP_SLVERR;
            cache_we_d    = okay_s;
            start_d       = okay_s & start_req_s;
            cache_addr_d  = {awaddr_q[ADDR_W-1:2], 2'b00};
            cache_wdata_d = wdata_q;
            cache_wstrb_d = wstrb_q;
        end else if (bvalid_q & bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
    end

    // State and output registers; reset discards slots and any pending B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            awaddr_q      <= 14'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            cache_we_q    <= 1'b0;
            start_q       <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= 32'd0;
            cache_wstrb_q <= 4'd0;
        end else begin
            aw_full_q     <= aw_full_d;
            w_full_q      <= w_full_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            cache_we_q    <= cache_we_d;
            start_q       <= start_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            cache_wstrb_q <= cache_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mxu_axi_wr_slave.sv
// Testbench for mxu_axi_wr_slave: scoreboard of expected cache writes and B
// responses, filled when a write is issued and drained by the per-cycle monitor.
module tb_mxu_axi_wr_slave;

`ifdef MXU_WR_BUSY_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] awaddr = 16'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        cache_we;
    logic [9:0]  cache_addr;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_wstrb;
    logic        start_pulse;
    logic        busy = 1'b0;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        st;
    } wexp_t;

    wexp_t      exp_w[$];
    logic [1:0] exp_b[$];
    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int b_cnt = 0;

    mxu_axi_wr_slave dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_wstrb(cache_wstrb), .start_pulse(start_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock, then act as the scoreboard monitor for that edge.
    task automatic cycle();
        logic       b_hs;
        logic [1:0] b_val;
        wexp_t      e;
        logic [1:0] eb;
        b_hs  = bvalid & bready;
        b_val = bresp;
        @(posedge clk);
        #1;
        if (b_hs === 1'b1) begin
            b_cnt++;
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected got=%b required=none", b_val);
            end else begin
                eb = exp_b.pop_front();
                if (b_val !== eb) begin
                    failures++;
                    $display("FAIL bresp got=%b required=%b", b_val, eb);
                end
            end
        end
        if (cache_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (exp_w.size() == 0) begin
                failures++;
                $display("FAIL we_unexpected addr=%0h data=%h", cache_addr, cache_wdata);
            end else begin
                e = exp_w.pop_front();
                if ({cache_addr, cache_wdata, cache_wstrb, start_pulse} !== e) begin
                    failures++;
                    $display("FAIL cache_write got=%0h/%h/%b/%b required=%0h/%h/%b/%b",
                             cache_addr, cache_wdata, cache_wstrb, start_pulse, e.a, e.d, e.s, e.st);
                end
            end
        end else if (start_pulse !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL start_without_we got=%b required=0", start_pulse);
        end
    endtask

    // Issue one write; AW and W start after their own delays (in cycles).
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        logic in_rng, streq, lk, ok, aw_done, w_done, aw_hs, w_hs;
        in_rng = ({a[15:2], 2'b11} < 16'd519);
        streq  = (a[15:2] == 14'd0) && s[0] && d[0];
        lk     = LOCK && busy && (({a[15:2], 2'b00} >= 16'd6) || streq);
        ok     = in_rng && !lk;
        exp_b.push_back(ok ? 2'b00 : 2'b10);
        if (ok) exp_w.push_back({a[9:2], 2'b00, d, s, streq});
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int k = 0; k < 200 && !(aw_done && w_done); k++) begin
            awvalid = !aw_done && (k >= aw_dly);
            awaddr  = a;
            wvalid  = !w_done && (k >= w_dly);
            wdata   = d;
            wstrb   = s;
            aw_hs   = awvalid & awready;
            w_hs    = wvalid & wready;
            cycle();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout aw=%b w=%b required=11", aw_done, w_done);
        end
    endtask

    task automatic drain_and_check(input string name);
        bready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (exp_w.size() != 0 || exp_b.size() != 0) begin
            failures++;
            $display("FAIL %s_pending we_left=%0d b_left=%0d required=0/0", name, exp_w.size(), exp_b.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        checks++;
        if ({awready, wready, bvalid, bresp, cache_we, cache_addr, cache_wdata, cache_wstrb, start_pulse} !== 52'd0) begin
            failures++;
            $display("FAIL reset_state got=%b%b%b%b%b %h/%h/%b/%b required=all0",
                     awready, wready, bvalid, bresp, cache_we, cache_addr, cache_wdata, cache_wstrb, start_pulse);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if ({awready, wready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_reset got=%b required=11", {awready, wready});
        end
    endtask

    task automatic test_basic();
        bready = 1'b0;
        do_write(16'h0010, 32'hAABBCCDD, 4'b1111, 0, 0);
        checks++;
        if (cache_we !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_we got=%b required=0", cache_we);
        end
        cycle();
        checks++;
        if ({cache_we, bvalid, bresp} !== 4'b1100) begin
            failures++;
            $display("FAIL basic_latency got=%b required=1100", {cache_we, bvalid, bresp});
        end
        bready = 1'b1;
        cycle();
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL basic_bclear got=%b required=0", bvalid);
        end
        drain_and_check("basic");
    endtask

    task automatic test_w_first();
        int w0;
        w0 = we_cnt;
        do_write(16'h0023, 32'h11223344, 4'b0101, 5, 0);
        drain_and_check("w_first");
        checks++;
        if (we_cnt - w0 != 1) begin
            failures++;
            $display("FAIL w_first_we_count got=%0d required=1", we_cnt - w0);
        end
    endtask

    task automatic test_range();
        logic [15:0] addrs [5] = '{16'h0208, 16'h0204, 16'h0200, 16'hFFFC, 16'h0001};
        logic [3:0]  strbs [5] = '{4'hF, 4'hF, 4'h3, 4'hF, 4'h0};
        int w0, b0;
        w0 = we_cnt;
        b0 = b_cnt;
        for (int i = 0; i < 5; i++) begin
            do_write(addrs[i], 32'h0000_0001 + 32'(i), strbs[i], 0, i % 2);
        end
        drain_and_check("range");
        checks++;
        if (we_cnt - w0 != 2 || b_cnt - b0 != 5) begin
            failures++;
            $display("FAIL range_counts we=%0d b=%0d required=2/5", we_cnt - w0, b_cnt - b0);
        end
    endtask

    task automatic test_start();
        do_write(16'h0000, 32'h00000001, 4'b0001, 0, 0);
        cycle();
        checks++;
        if ({start_pulse, cache_we} !== 2'b11) begin
            failures++;
            $display("FAIL start_pulse got=%b required=11", {start_pulse, cache_we});
        end
        cycle();
        checks++;
        if ({start_pulse, cache_we} !== 2'b00) begin
            failures++;
            $display("FAIL start_width got=%b required=00", {start_pulse, cache_we});
        end
        drain_and_check("start");
    endtask

    task automatic test_back_to_back();
        int w0;
        bready = 1'b0;
        do_write(16'h0030, 32'hCAFE0001, 4'b1111, 0, 0);
        do_write(16'h0034, 32'hCAFE0002, 4'b1100, 0, 0);
        checks++;
        if ({awready, wready} !== 2'b00) begin
            failures++;
            $display("FAIL bp_ready_drop got=%b required=00", {awready, wready});
        end
        w0 = we_cnt;
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (we_cnt != w0 || bvalid !== 1'b1 || bresp !== 2'b00) begin
            failures++;
            $display("FAIL bp_hold we=%0d bvalid=%b bresp=%b required=0/1/00", we_cnt - w0, bvalid, bresp);
        end
        drain_and_check("back_to_back");
        checks++;
        if (we_cnt - w0 != 1) begin
            failures++;
            $display("FAIL bp_second_we got=%0d required=1", we_cnt - w0);
        end
    endtask

    task automatic test_busy();
        int w0;
        w0 = we_cnt;
        busy = 1'b1;
        do_write(16'h0040, 32'h12345678, 4'b1111, 0, 0);
        do_write(16'h0004, 32'h9ABCDEF0, 4'b0011, 0, 0);
        do_write(16'h0000, 32'h00000001, 4'b0001, 0, 0);
        drain_and_check("busy");
        busy = 1'b0;
        checks++;
        if (we_cnt - w0 != (LOCK ? 1 : 3)) begin
            failures++;
            $display("FAIL busy_we_count got=%0d required=%0d", we_cnt - w0, LOCK ? 1 : 3);
        end
    endtask

    task automatic test_reset_mid();
        bready = 1'b0;
        do_write(16'h0050, 32'hDEADBEEF, 4'b1111, 0, 0);
        reset = 1'b1;
        exp_w.delete();
        exp_b.delete();
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            failures++;
            $display("FAIL reset_slots got=%b required=011", {bvalid, awready, wready});
        end
        do_write(16'h0060, 32'h01020304, 4'b1111, 0, 0);
        cycle();
        reset = 1'b1;
        exp_b.delete();
        #1;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending_b got=%b required=0", bvalid);
        end
        cycle();
        reset = 1'b0;
        drain_and_check("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_range();
        test_start();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
